serial_to_parallel_rx: RTL and testbench

Receive-side serial-to-parallel converter with comma alignment, directly upstream of the layer-2 demux. It samples the 1-bit serial lane at `clk_32f` and finds the byte boundary from 0xBC commas. It asserts `active` after enough consecutive commas, then presents each 8-bit byte on `data_rx000`/`valid_rx000` for the demux, which samples at `clk_4f`. Commas are idle fill and never reach the demux as valid data.

---
 rtl/phy_rx_pkg.sv | 16 +
 rtl/serial_rx_shifter.sv | 39 +++
 rtl/serial_to_parallel_rx.sv | 119 +++++++++++
 tb/tb_serial_to_parallel_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// Shared definitions for the receive PHY: symbol width, comma symbol,
// lock threshold defaults and the aligner state type.
package phy_rx_pkg;

    localparam int         WIDTH      = 8;
    localparam logic [7:0] COMMA      = 8'hBC;
    localparam int         LOCK_COUNT = 4;
    localparam int         CNT_W      = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_rx_shifter.sv
// Serial shift register and bit counter for the receive lane.
// next_byte is the byte that would be complete if this edge were a boundary;
// boundary flags the edge that closes a byte. realign restarts the bit count
// so the edge after a comma match starts a fresh byte.
module serial_rx_shifter
    import phy_rx_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk_32f,
    input  logic         reset,
    input  logic         data_in,
    input  logic         realign,
    output logic [W-1:0] next_byte,
    output logic         boundary
);

    localparam int CW = $clog2(W);

    // Only the newest W-1 bits need storing; the oldest bit of the byte
    // shifts out on the edge that completes it.
    logic [W-2:0] shreg;
    logic [CW-1:0] bit_cnt;

    assign next_byte = {shreg, data_in};
    assign boundary  = (bit_cnt == CW'(W - 1));

    // Shift in one bit per edge; bit counter wraps naturally or restarts on realign.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            shreg   <= next_byte[W-2:0];
            bit_cnt <= realign ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver with comma lock, feeding the layer-2 demux.
// Outputs only move on byte boundaries, so they are stable for a full clk_4f
// period. Commas are idle fill and never show as valid payload.
// Build option: RX_COMMA_ALIGN_EN enables sliding per-bit comma search;
// without it the byte phase is fixed by reset release.
module serial_to_parallel_rx
    import phy_rx_pkg::*;
#(
    parameter int               WIDTH      = phy_rx_pkg::WIDTH,
    parameter logic [WIDTH-1:0] COMMA      = phy_rx_pkg::COMMA,
    parameter int               LOCK_COUNT = phy_rx_pkg::LOCK_COUNT
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_rx000,
    output logic             valid_rx000,
    output logic             active
);

`ifdef RX_COMMA_ALIGN_EN
    localparam rx_state_t RST_STATE = SEARCH;
`else
    localparam rx_state_t RST_STATE = COUNT;
`endif

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] comma_cnt, cnt_nxt, cnt_inc;
    logic [WIDTH-1:0] data_nxt, next_byte;
    logic             valid_nxt, active_nxt;
    logic             boundary, realign, is_comma;

    serial_rx_shifter #(.W(WIDTH)) u_shifter (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .realign   (realign),
        .next_byte (next_byte),
        .boundary  (boundary)
    );

    assign is_comma = (next_byte == COMMA);
    assign cnt_inc  = comma_cnt + 1'b1;

    // State, comma counter and output registers.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state       <= RST_STATE;
            comma_cnt   <= '0;
            data_rx000  <= '0;
            valid_rx000 <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_nxt;
            comma_cnt   <= cnt_nxt;
            data_rx000  <= data_nxt;
            valid_rx000 <= valid_nxt;
            active      <= active_nxt;
        end
    end

    // Next-state and output decode; everything holds unless a rule fires.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = comma_cnt;
        data_nxt   = data_rx000;
        valid_nxt  = valid_rx000;
        active_nxt = active;
        realign    = 1'b0;
        case (state)
`ifdef RX_COMMA_ALIGN_EN
            SEARCH: begin
                valid_nxt = 1'b0;
                if (is_comma) begin
                    // Comma at any bit phase fixes the byte boundary here.
                    realign  = 1'b1;
                    data_nxt = COMMA;
                    cnt_nxt  = CNT_W'(1);
                    if (LOCK_COUNT == 1) begin
                        state_nxt  = ACTIVE;
                        active_nxt = 1'b1;
                    end else begin
                        state_nxt = COUNT;
                    end
                end else if (boundary) begin
                    data_nxt = next_byte;
                end
            end
`endif
            COUNT: begin
                valid_nxt = 1'b0;
                if (boundary) begin
                    data_nxt = next_byte;
                    if (is_comma) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_W'(LOCK_COUNT)) begin
                            state_nxt  = ACTIVE;
                            active_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = '0;
`ifdef RX_COMMA_ALIGN_EN
                        state_nxt = SEARCH;
`endif
                    end
                end
            end
            ACTIVE: begin
                // Locked for good: only reset leaves this state.
                if (boundary) begin
                    data_nxt  = next_byte;
                    valid_nxt = !is_comma;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx: reset behaviour, lock and
// payload table, comma-run restart, mid-byte reset, randomized byte streams
// against a byte-level model, and (align builds) arbitrary phase offset.
module tb_serial_to_parallel_rx;

    localparam logic [7:0] BC   = 8'hBC;
    localparam int         LOCK = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_rx000;
    logic       valid_rx000;
    logic       active;

    int total = 0;
    int bad   = 0;

    // byte-level reference: run of consecutive commas and lock flag
    int m_run  = 0;
    bit m_lock = 1'b0;

    typedef struct {
        logic [7:0] b;
        logic [7:0] d;
        logic       v;
        logic       a;
    } vec_t;

    vec_t tbl [10];

    serial_to_parallel_rx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_rx000  (data_rx000),
        .valid_rx000 (valid_rx000),
        .active      (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input logic [7:0] d, input logic v, input logic a);
        chk8({nm, "_data"}, data_rx000, d);
        chk1({nm, "_valid"}, valid_rx000, v);
        chk1({nm, "_active"}, active, a);
    endtask

    // Send one byte MSB first; inputs change 1 unit after each rising edge.
    // Mid-byte the outputs must still hold their previous values.
    task automatic send_byte(input logic [7:0] b);
        logic [7:0] d0;
        logic       v0;
        d0 = data_rx000;
        v0 = valid_rx000;
        for (int i = 7; i >= 0; i--) begin
            data_in = b[i];
            @(posedge clk_32f);
            #1;
            if (i == 4) begin
                chk8("hold_data", data_rx000, d0);
                chk1("hold_valid", valid_rx000, v0);
            end
        end
    endtask

    task automatic send_bit(input logic v);
        data_in = v;
        @(posedge clk_32f);
        #1;
    endtask

    // Assert reset 1 unit after an edge, check async clear, release before next edge.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk_out("rst_async", 8'h00, 1'b0, 1'b0);
        data_in = 1'($urandom_range(0, 1));
        @(posedge clk_32f);
        #1;
        chk_out("rst_held", 8'h00, 1'b0, 1'b0);
        reset  = 1'b1;
        m_run  = 0;
        m_lock = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, output logic [7:0] ed,
                              output logic ev, output logic ea);
        ed = b;
        if (m_lock) begin
            ev = (b != BC);
        end else begin
            ev = 1'b0;
            if (b == BC) begin
                m_run++;
                if (m_run >= LOCK) m_lock = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        ea = m_lock;
    endtask

    task automatic send_and_model(input string nm, input logic [7:0] b);
        logic [7:0] ed;
        logic       ev, ea;
        send_byte(b);
        model_byte(b, ed, ev, ea);
        chk_out(nm, ed, ev, ea);
    endtask

    initial begin
        logic [7:0] seq2 [8];
        logic [7:0] act2;
        logic [7:0] b;

        tbl[0] = '{BC,    BC,    1'b0, 1'b0};
        tbl[1] = '{BC,    BC,    1'b0, 1'b0};
        tbl[2] = '{BC,    BC,    1'b0, 1'b0};
        tbl[3] = '{BC,    BC,    1'b0, 1'b1};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 1'b1};
        tbl[5] = '{8'hDD, 8'hDD, 1'b1, 1'b1};
        tbl[6] = '{8'hEE, 8'hEE, 1'b1, 1'b1};
        tbl[7] = '{8'h77, 8'h77, 1'b1, 1'b1};
        tbl[8] = '{BC,    BC,    1'b0, 1'b1};
        tbl[9] = '{8'h55, 8'h55, 1'b1, 1'b1};

        seq2[0] = BC; seq2[1] = BC; seq2[2] = BC; seq2[3] = 8'h12;
        seq2[4] = BC; seq2[5] = BC; seq2[6] = BC; seq2[7] = BC;
        act2 = 8'b1000_0000;  // bit i = expected active after seq2[i]

        // Power-on reset for 13 time units with a noisy lane.
        for (int i = 0; i < 3; i++) begin
            data_in = 1'($urandom_range(0, 1));
            #4;
            chk_out("por", 8'h00, 1'b0, 1'b0);
        end
        data_in = 1'($urandom_range(0, 1));
        #1;
        reset = 1'b1;

        // Aligned lock followed by payload and an embedded comma.
        for (int i = 0; i < 10; i++) begin
            send_byte(tbl[i].b);
            chk_out("tbl", tbl[i].d, tbl[i].v, tbl[i].a);
        end

        // Randomized payload while locked.
        m_lock = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b = ($urandom_range(0, 3) == 0) ? BC : 8'($urandom);
            send_and_model("rnd_locked", b);
        end

        // Interrupted comma run must not lock; a fresh run of four does.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_byte(seq2[i]);
            chk8("run_data", data_rx000, seq2[i]);
            chk1("run_valid", valid_rx000, 1'b0);
            chk1("run_active", active, act2[i]);
        end
        send_byte(8'h77);
        chk_out("run_payload", 8'h77, 1'b1, 1'b1);

        // Reset in the middle of a byte while locked.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset();
        send_byte(8'h55);
        chk_out("relock_55", 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte(BC);
            chk_out("relock_bc", BC, 1'b0, 1'b0);
        end
        send_byte(BC);
        chk_out("relock_4th", BC, 1'b0, 1'b1);
        send_byte(8'h3C);
        chk_out("relock_pay", 8'h3C, 1'b1, 1'b1);

        // Randomized comma/idle stream from reset; 0x00 and 0xBC cannot form a
        // comma at a wrong bit phase, so the boundary stays where reset put it.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            b = ($urandom_range(0, 3) != 0) ? BC : 8'h00;
            send_and_model("rnd_prelock", b);
        end
        for (int i = 0; i < 10; i++) begin
            send_and_model("rnd_after", 8'($urandom));
        end

`ifdef RX_COMMA_ALIGN_EN
        // Three junk bits shift the byte phase; the aligner must follow.
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) begin
            send_byte(BC);
            chk_out("align_bc", BC, 1'b0, 1'b0);
        end
        send_byte(BC);
        chk_out("align_4th", BC, 1'b0, 1'b1);
        send_byte(8'hAA);
        chk_out("align_aa", 8'hAA, 1'b1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
